// File: rtl/nodo_inyector.sv
// nodo_inyector: packet injection stage at the network edge.
// Collects DATA_FLITS payload words plus a destination/tag from the local
// processing element. It then checks the destination and waits for a
// downstream packet credit. Finally it streams header + data flits back to
// back on channel_dout.
// Optional feature macro: NODO_INYECTOR_CREDIT_CHECK_EN. When defined, a
// credit returned while the counter is already full raises a sticky
// credit_error_dout. When undefined, that output is tied low.

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 32
`endif
`ifndef DATA_FLITS
`define DATA_FLITS 4
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 10
`endif
`ifndef HEADER_FIELD
`define HEADER_FIELD 31
`endif
`ifndef WITNESS_FIELD
`define WITNESS_FIELD 30
`endif

module nodo_inyector #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int CREDITS = `BUFFER_DEPTH / 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                dest_x_din,
  input  logic [2:0]                dest_y_din,
  input  logic [23:0]               tag_din,
  input  logic                      data_valid_din,
  input  logic [`CHANNEL_WIDTH-1:0] data_din,
  output logic                      data_ready_dout,
  output logic [`CHANNEL_WIDTH-1:0] channel_dout,
  input  logic                      credit_in_din,
  output logic                      drop_dout,
  output logic                      busy_dout,
  output logic                      credit_error_dout
);

  localparam int Flits   = `DATA_FLITS;
  localparam int CntW    = (Flits > 1) ? $clog2(Flits) : 1;
  localparam int CreditW = $clog2(CREDITS) + 1;

  localparam logic [CntW-1:0]    LastIdx   = CntW'(Flits - 1);
  localparam logic [CreditW-1:0] CreditMax = CreditW'(CREDITS);
  localparam logic [2:0]         XMax      = 3'(X_WIDTH);
  localparam logic [2:0]         YMax      = 3'(Y_WIDTH);

  typedef enum logic [1:0] {
    StLoad,
    StCheck,
    StWait,
    StSend
  } state_t;

  state_t                    state_q;
  logic [CntW-1:0]           loadCnt_q;
  logic [CntW-1:0]           sendCnt_q;
  logic                      lastFlit_q;
  logic [`CHANNEL_WIDTH-1:0] payload_q [Flits];
  logic [2:0]                destX_q;
  logic [2:0]                destY_q;
  logic [23:0]               tag_q;
  logic                      destOk_q;
  logic [CreditW-1:0]        credit_q;
  logic [CreditW-1:0]        credit_d;
  logic                      ready_q;
  logic                      drop_q;
  logic                      busy_q;
  logic [`CHANNEL_WIDTH-1:0] channel_q;

  logic                      wordAccept;
  logic                      lastWord;
  logic                      destOkIn;
  logic                      creditTake;
  logic [`CHANNEL_WIDTH-1:0] headerFlit;

  assign wordAccept = (state_q == StLoad) && ready_q && data_valid_din;
  assign lastWord   = (loadCnt_q == LastIdx);
  assign destOkIn   = (dest_x_din != 3'd0) && (dest_x_din <= XMax) &&
                      (dest_y_din != 3'd0) && (dest_y_din <= YMax);
  // A credit is consumed exactly when a waiting packet is released to SEND.
  assign creditTake = (state_q == StWait) && (credit_q != '0);

  // Assemble the header flit from the latched destination and tag.
  always_comb begin
    headerFlit                 = '0;
    headerFlit[`HEADER_FIELD]  = 1'b1;
    headerFlit[`WITNESS_FIELD] = 1'b0;
    headerFlit[29:27]          = destX_q;
    headerFlit[26:24]          = destY_q;
    headerFlit[23:0]           = tag_q;
  end

  // Next credit count: return and take cancel, returns saturate at full.
  always_comb begin
    credit_d = credit_q;
    if (credit_in_din && !creditTake) begin
      if (credit_q != CreditMax) begin
        credit_d = credit_q + 1'b1;
      end
    end else if (creditTake && !credit_in_din) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // Credit counter starts full so the first CREDITS packets go out at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_q <= CreditMax;
    end else begin
      credit_q <= credit_d;
    end
  end

  // Staging storage: payload words plus destination/tag taken with word 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      destX_q  <= 3'd0;
      destY_q  <= 3'd0;
      tag_q    <= 24'd0;
      destOk_q <= 1'b0;
    end else if (wordAccept) begin
      payload_q[loadCnt_q] <= data_din;
      if (loadCnt_q == '0) begin
        destX_q  <= dest_x_din;
        destY_q  <= dest_y_din;
        tag_q    <= tag_din;
        destOk_q <= destOkIn;
      end
    end
  end

  // Packet FSM with registered outputs that already reflect the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StLoad;
      loadCnt_q  <= '0;
      sendCnt_q  <= '0;
      lastFlit_q <= 1'b0;
      ready_q    <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      channel_q  <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        StLoad: begin
          ready_q   <= 1'b1;
          channel_q <= '0;
          if (wordAccept) begin
            busy_q <= 1'b1;
            if (lastWord) begin
              loadCnt_q <= '0;
              state_q   <= StCheck;
              ready_q   <= 1'b0;
              drop_q    <= (loadCnt_q == '0) ? !destOkIn : !destOk_q;
            end else begin
              loadCnt_q <= loadCnt_q + 1'b1;
            end
          end
        end
        StCheck: begin
          if (drop_q) begin
            state_q <= StLoad;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (creditTake) begin
            state_q    <= StSend;
            channel_q  <= headerFlit;
            sendCnt_q  <= '0;
            lastFlit_q <= 1'b0;
          end
        end
        StSend: begin
          if (lastFlit_q) begin
            state_q    <= StLoad;
            channel_q  <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            lastFlit_q <= 1'b0;
          end else begin
            channel_q <= payload_q[sendCnt_q];
            if (sendCnt_q == LastIdx) begin
              lastFlit_q <= 1'b1;
              sendCnt_q  <= '0;
            end else begin
              sendCnt_q <= sendCnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

`ifdef NODO_INYECTOR_CREDIT_CHECK_EN
  logic creditErr_q;

  // Sticky flag: downstream returned a credit we never consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      creditErr_q <= 1'b0;
    end else if (credit_in_din && (credit_q == CreditMax)) begin
      creditErr_q <= 1'b1;
    end
  end

  assign credit_error_dout = creditErr_q;
`else
  assign credit_error_dout = 1'b0;
`endif

  assign data_ready_dout = ready_q;
  assign channel_dout    = channel_q;
  assign drop_dout       = drop_q;
  assign busy_dout       = busy_q;

endmodule

// File: tb/tb_nodo_inyector.sv
// tb_nodo_inyector: drives directed and random packets into nodo_inyector.
// Every cycle, each output is compared against a queue-based packet model.
// Literal header/flit values pin the model for the key scenarios.

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 32
`endif
`ifndef DATA_FLITS
`define DATA_FLITS 4
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 10
`endif

module tb_nodo_inyector;

  localparam int Flits   = `DATA_FLITS;
  localparam int Credits = `BUFFER_DEPTH / 5;
  localparam int XW      = 2;
  localparam int YW      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  destX;
  logic [2:0]  destY;
  logic [23:0] tag;
  logic        dataValid;
  logic [31:0] data;
  logic        dataReady;
  logic [31:0] channel;
  logic        creditIn;
  logic        drop;
  logic        busy;
  logic        creditError;

  nodo_inyector dut (
    .clk               (clk),
    .reset             (reset),
    .dest_x_din        (destX),
    .dest_y_din        (destY),
    .tag_din           (tag),
    .data_valid_din    (dataValid),
    .data_din          (data),
    .data_ready_dout   (dataReady),
    .channel_dout      (channel),
    .credit_in_din     (creditIn),
    .drop_dout         (drop),
    .busy_dout         (busy),
    .credit_error_dout (creditError)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        expReady;
  logic        expDrop;
  logic        expBusy;
  logic        expErr;
  logic [31:0] expChan;
  int          mCredits;
  bit          mTx;
  bit          mWait;
  bit          mCheck;
  bit          mOk;
  logic [2:0]  mx;
  logic [2:0]  my;
  logic [23:0] mTag;
  logic [31:0] words[$];
  logic [31:0] txQ[$];

  task automatic compareBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic compareWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    compareBit("ready", dataReady, expReady);
    compareBit("drop", drop, expDrop);
    compareBit("busy", busy, expBusy);
    compareBit("creditErr", creditError, expErr);
    compareWord("channel", channel, expChan);
  endtask

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
    checkOutput();
  endtask

  // Packet-level model: words gather into a packet, which is checked, then
  // waits for a credit, then is replayed from a flit queue.
  task automatic modelAdvance(input bit rst, input bit v, input logic [31:0] d,
                              input logic [2:0] dx, input logic [2:0] dy,
                              input logic [23:0] tg, input bit cin);
    bit take;
    if (!rst) begin
      expReady = 1'b0;
      expDrop  = 1'b0;
      expBusy  = 1'b0;
      expErr   = 1'b0;
      expChan  = '0;
      mCredits = Credits;
      mTx      = 1'b0;
      mWait    = 1'b0;
      mCheck   = 1'b0;
      words.delete();
      txQ.delete();
    end else begin
      take = mWait && (mCredits > 0);
`ifdef NODO_INYECTOR_CREDIT_CHECK_EN
      if (cin && mCredits == Credits) expErr = 1'b1;
`endif
      if (cin && !take) begin
        if (mCredits < Credits) mCredits++;
      end else if (take && !cin) begin
        mCredits--;
      end
      expDrop = 1'b0;
      if (mTx) begin
        if (txQ.size() > 0) begin
          expChan = txQ.pop_front();
        end else begin
          expChan  = '0;
          mTx      = 1'b0;
          expReady = 1'b1;
          expBusy  = 1'b0;
        end
      end else if (mWait) begin
        if (take) begin
          mWait   = 1'b0;
          mTx     = 1'b1;
          expChan = {1'b1, 1'b0, mx, my, mTag};
          txQ     = words;
          words.delete();
        end
      end else if (mCheck) begin
        mCheck = 1'b0;
        if (mOk) begin
          mWait = 1'b1;
        end else begin
          expReady = 1'b1;
          expBusy  = 1'b0;
          words.delete();
        end
      end else begin
        if (expReady && v) begin
          words.push_back(d);
          if (words.size() == 1) begin
            mx   = dx;
            my   = dy;
            mTag = tg;
          end
          expBusy = 1'b1;
          if (words.size() == Flits) begin
            mCheck  = 1'b1;
            mOk     = (int'(mx) >= 1) && (int'(mx) <= XW) &&
                      (int'(my) >= 1) && (int'(my) <= YW);
            expDrop = !mOk;
          end
        end
        expReady = !mCheck;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] d,
                               input logic [2:0] dx, input logic [2:0] dy,
                               input logic [23:0] tg, input bit cin);
    reset     = rst;
    dataValid = v;
    data      = d;
    destX     = dx;
    destY     = dy;
    tag       = tg;
    creditIn  = cin;
    modelAdvance(rst, v, d, dx, dy, tg, cin);
  endtask

  task automatic applyIdle(input bit cin);
    applyStimulus(1'b1, 1'b0, 32'd0, 3'd0, 3'd0, 24'd0, cin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      applyIdle(1'b0);
    end
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (i > 0) begin
        compareBit("rstReady", dataReady, 1'b0);
        compareWord("rstChan", channel, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 24'd0, 1'b0);
    end
    nextCycle();
    applyIdle(1'b0);
  endtask

  task automatic loadPacket(input logic [2:0] dx, input logic [2:0] dy,
                            input logic [23:0] tg, input logic [31:0] base);
    for (int i = 0; i < Flits; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, base + 32'(i), dx, dy, tg, 1'b0);
    end
  endtask

  task automatic waitHeader(input string name, input logic [31:0] hdr, input int lag);
    for (int j = 1; j <= lag; j++) begin
      nextCycle();
      if (j == lag) compareWord(name, channel, hdr);
      applyIdle(1'b0);
    end
  endtask

  // Directed scenarios followed by a long randomized run.
  initial begin
    reset     = 1'b0;
    dataValid = 1'b0;
    data      = '0;
    destX     = '0;
    destY     = '0;
    tag       = '0;
    creditIn  = 1'b0;
    modelAdvance(1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 24'd0, 1'b0);

    doReset();

    // Invalid destinations are dropped without touching credits.
    loadPacket(3'd0, 3'd1, 24'h000011, 32'hD0000000);
    nextCycle();
    compareBit("dropX0", drop, 1'b1);
    compareWord("dropChan", channel, 32'd0);
    applyIdle(1'b0);
    nextCycle();
    compareBit("dropReady", dataReady, 1'b1);
    applyIdle(1'b0);
    loadPacket(3'd3, 3'd1, 24'h000022, 32'hD1000000);
    nextCycle();
    compareBit("dropX3", drop, 1'b1);
    applyIdle(1'b0);
    nextCycle();
    compareBit("dropX3Ready", dataReady, 1'b1);
    applyIdle(1'b0);

    // Basic packet: header 3 cycles after the last word, then four data flits.
    loadPacket(3'd1, 3'd2, 24'h00ABCD, 32'hA0000000);
    for (int j = 1; j <= 8; j++) begin
      nextCycle();
      if (j == 1) compareBit("checkNotReady", dataReady, 1'b0);
      if (j == 3) compareWord("hdrBasic", channel, 32'h8A00ABCD);
      if (j >= 4 && j <= 7) compareWord("dataBasic", channel, 32'hA0000000 + 32'(j - 4));
      if (j == 8) compareBit("readyAfterSend", dataReady, 1'b1);
      applyIdle(1'b0);
    end

    // Credit return coincident with WAIT->SEND leaves the count at 1.
    loadPacket(3'd2, 3'd1, 24'h000001, 32'hB0000000);
    nextCycle();
    applyIdle(1'b0);
    nextCycle();
    applyIdle(1'b1);
    nextCycle();
    compareWord("hdrCoincident", channel, 32'h91000001);
    applyIdle(1'b0);
    idle(5);

    // The one remaining credit lets the next packet go out immediately.
    loadPacket(3'd2, 3'd2, 24'h000002, 32'hC0000000);
    waitHeader("hdrSecond", 32'h92000002, 3);
    idle(5);

    // Out of credits: packet holds, then leaves 2 cycles after a return.
    loadPacket(3'd1, 3'd1, 24'h000003, 32'hE0000000);
    for (int j = 1; j <= 6; j++) begin
      nextCycle();
      if (j >= 3) begin
        compareBit("holdBusy", busy, 1'b1);
        compareWord("holdChan", channel, 32'd0);
      end
      applyIdle(j == 6);
    end
    nextCycle();
    compareWord("holdChanAfterCredit", channel, 32'd0);
    applyIdle(1'b0);
    nextCycle();
    compareWord("hdrAfterCredit", channel, 32'h89000003);
    applyIdle(1'b0);
    idle(5);

    // Reset during the second data flit abandons the packet and refills credits.
    nextCycle();
    applyIdle(1'b1);
    loadPacket(3'd1, 3'd2, 24'hBEEF00, 32'hF0000000);
    waitHeader("hdrPreReset", 32'h8ABEEF00, 3);
    nextCycle();
    applyIdle(1'b0);
    nextCycle();
    compareWord("secondFlit", channel, 32'hF0000001);
    applyStimulus(1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 24'd0, 1'b0);
    nextCycle();
    compareWord("rstMidChan", channel, 32'd0);
    compareBit("rstMidBusy", busy, 1'b0);
    compareBit("rstMidReady", dataReady, 1'b0);
    applyIdle(1'b0);
    nextCycle();
    compareBit("releaseReady", dataReady, 1'b1);
    applyIdle(1'b0);
    loadPacket(3'd2, 3'd1, 24'h123456, 32'h50000000);
    waitHeader("hdrFresh", 32'h91123456, 3);
    idle(5);
    loadPacket(3'd1, 3'd1, 24'h000777, 32'h60000000);
    waitHeader("hdrRefilled", 32'h89000777, 3);
    idle(5);

    // Credit return while already full.
    doReset();
    nextCycle();
    applyIdle(1'b1);
    nextCycle();
`ifdef NODO_INYECTOR_CREDIT_CHECK_EN
    compareBit("errSet", creditError, 1'b1);
`else
    compareBit("errTied", creditError, 1'b0);
`endif
    applyIdle(1'b0);
    idle(3);
    doReset();
    nextCycle();
    compareBit("errCleared", creditError, 1'b0);
    applyIdle(1'b0);

    // Randomized traffic with occasional resets, checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 9) < 7,
                    $urandom,
                    3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)),
                    24'($urandom),
                    $urandom_range(0, 7) == 0);
    end
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
